sub_vec_ctrl: RTL
=================

// Module: sub_vec_ctrl
// PURPOSE
//  Sequencer for element-wise vector subtraction C[i] = (A[i] - B[i]) mod q over sync-read RAMs.
//  Streams one element per cycle through an internal instance of the `sub` datapath.
//  Sits in the FrodoKEM top level beside the matrix engines; used for decapsulation C - B'S style steps.
//  Start/done handshake; supports security levels L1 (q = 2^15) and L5 (q = 2^16).
// PARAMETERS
//  WIDTH       16   element width; the `sub` datapath uses the same width
//  ADDR_WIDTH  11   RAM address width; all address arithmetic wraps modulo 2^ADDR_WIDTH
//  LEN_WIDTH   12   width of the element count i_len
// PORTS
//  i_clk          in   1           clock
//  i_rst_n        in   1           asynchronous reset, active-low
//  i_start        in   1           start pulse; sampled only in IDLE
//  i_clear        in   1           synchronous abort; returns the block to IDLE
//  i_sec_lev      in   3           3'b001 selects L1; any other value selects L5; latched at start
//  i_len          in   LEN_WIDTH   number of elements
//  i_base_a       in   ADDR_WIDTH  A base address
//  i_base_b       in   ADDR_WIDTH  B base address
//  i_base_c       in   ADDR_WIDTH  C base address; all three bases latched at start
//  o_rd_en        out  1           read strobe for both A and B RAMs
//  o_rd_addr_a    out  ADDR_WIDTH  A read address
//  o_rd_addr_b    out  ADDR_WIDTH  B read address
//  i_rd_data_a    in   WIDTH       A data, valid 1 cycle after o_rd_en
//  i_rd_data_b    in   WIDTH       B data, valid 1 cycle after o_rd_en
//  o_wr_en        out  1           C write strobe
//  o_wr_addr      out  ADDR_WIDTH  C write address
//  o_wr_data      out  WIDTH       C write data
//  o_busy         out  1           high from start acceptance until DONE
//  o_done         out  1           1-cycle pulse when the last write has completed
//  o_range_err    out  1           sticky operand range error; see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; counters 0; pipeline valids cleared.
//  FSM states:
//   IDLE:  on i_start, latch bases, len and sec_lev; go to RUN if len != 0, else DONE.
//   RUN:   assert o_rd_en with address base + idx; increment idx every cycle.
//          After issuing idx = len-1, go to DRAIN.
//   DRAIN: wait until both pipeline valids are 0, then go to DONE.
//   DONE:  o_done = 1 for 1 cycle; go to IDLE.
//  Pipeline:
//   Stage 0: read issue.
//   Stage 1: RAM data arrives; `sub` evaluated combinationally.
//   Stage 2: o_wr_* registered.
//  Timing: start accepted at cycle 0; read k issued at cycle 1+k; write k at cycle 3+k;
//   o_done at cycle len+3. Throughput 1 element per cycle; no bubbles.
//  Arithmetic: `sub` semantics.
//   L5: (a - b) mod 2^16.
//   L1: (a - b) mod 2^15 with bit 15 of the result forced to 0.
//  o_wr_addr = base_c + k, wrapping modulo 2^ADDR_WIDTH.
//  o_busy: 1 in RUN, DRAIN and DONE; 0 in IDLE.
//  i_start while not in IDLE: ignored, no side effects.
//  len == 0: DONE at cycle 1, o_done at cycle 1, no reads, no writes.
//  i_clear: takes priority over every other event in the same cycle.
//   FSM -> IDLE, pipeline valids cleared, no further writes, no o_done.
//   Takes effect from the next edge; o_range_err is also cleared.
//  i_start and i_clear in the same cycle: i_clear wins; the start is dropped.
//  Reset mid-operation: the same as i_clear, but asynchronous.
//  i_sec_lev or base changes during an operation have no effect.
// CONFIGURATION
//  Macro SUB_VEC_CTRL_RANGE_CHECK_EN.
//  Defined: at stage 1, if L1 and bit 15 of either operand is 1, set o_range_err.
//   o_range_err stays set until the next accepted start, i_clear or reset.
//   The write still occurs, using the `sub` result.
//  Undefined: o_range_err tied to 0 and no check logic is built.
// STRUCTURE
//  L1_Q and L5_Q come from common/param.v; no local copies.
//  FSM state encodings are localparams in this file.
//  One sub-module: `sub` (WIDTH), driven by the stage-1 data and the latched sec_lev.
//  The FSM, address counters and pipeline valids live in this module.
// TESTING
//  L5, len=1, A[0]=5, B[0]=7 -> write 65534 at base_c at cycle 3; o_done at cycle 4.
//  L1, len=4, A={5,0,100,32767}, B={7,1,100,0} -> C={32766,32767,0,32767}, consecutive addresses.
//  base_c=2047, len=3, ADDR_WIDTH=11 -> writes at addresses 2047, 0, 1 (wrap).
//  len=0 -> o_done at cycle 1, o_rd_en and o_wr_en never asserted.
//  len=8, i_start re-pulsed at cycle 4, i_clear at cycle 6
//   -> the re-pulse is ignored; no writes after cycle 6; no o_done; o_busy=0 at cycle 7.
//  Macro defined, L1, A[0]=0x8001 -> o_range_err=1 at cycle 3; stays 1 until the next start.
//   Macro undefined -> o_range_err=0.

Source files
------------

// File: rtl/sub_vec_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sub_vec_ctrl_pkg
//   Shared constants for the vector-subtraction sequencer and its `sub`
//   datapath: the FrodoKEM moduli for the two supported security levels and
//   the sec_lev code that selects L1.
// -----------------------------------------------------------------------------
package sub_vec_ctrl_pkg;

   // Moduli of the supported parameter sets.
   localparam int L1_Q      = 1 << 15;
   localparam int L5_Q      = 1 << 16;

   // log2(L1_Q): position of the first bit that must be zero in an L1 value.
   localparam int L1_Q_BITS = 15;

   // sec_lev encoding; every other code selects L5.
   localparam logic [2:0] SEC_LEV_L1 = 3'b001;

   function automatic logic sel_l1(input logic [2:0] sec_lev);
      return (sec_lev == SEC_LEV_L1);
   endfunction

endpackage

// File: rtl/sub_vec_ctrl_sub.sv
// -----------------------------------------------------------------------------
// sub_vec_ctrl_sub  (the `sub` datapath)
//   Combinational modular subtraction c = (a - b) mod q.
//     L5: q = 2^16
//     L1: q = 2^15, bit 15 of the result is forced to 0
// Ports
//   a, b   : operands, WIDTH bits
//   is_l1  : 1 selects the L1 modulus, 0 selects L5
//   c      : reduced difference, WIDTH bits
// -----------------------------------------------------------------------------
module sub_vec_ctrl_sub
   import sub_vec_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_l1,
   output logic [WIDTH-1:0] c
);

   localparam logic [WIDTH-1:0] L1_MASK = WIDTH'(L1_Q - 1);
   localparam logic [WIDTH-1:0] L5_MASK = WIDTH'(L5_Q - 1);

   // Both moduli are powers of two, so the reduction of the two's-complement
   // difference is a simple mask of its low bits.
   function automatic logic [WIDTH-1:0] reduce_q(input logic [WIDTH-1:0] d,
                                                 input logic             l1);
      return l1 ? (d & L1_MASK) : (d & L5_MASK);
   endfunction

   logic signed [WIDTH-1:0] diff;

   assign diff = $signed(a) - $signed(b);
   assign c    = reduce_q(diff, is_l1);

endmodule

// File: rtl/sub_vec_ctrl.sv
// -----------------------------------------------------------------------------
// sub_vec_ctrl
//   Sequencer for element-wise vector subtraction C[i] = (A[i] - B[i]) mod q
//   over synchronous-read RAMs, one element per cycle through the `sub`
//   datapath. Start/done handshake, security levels L1 (q = 2^15) and
//   L5 (q = 2^16).
//
// Optional feature: define SUB_VEC_CTRL_RANGE_CHECK_EN to build the L1
//   operand range check driving o_range_err; otherwise o_range_err is 0.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               start pulse, only looked at in IDLE
//   i_clear               synchronous abort back to IDLE (highest priority)
//   i_sec_lev             3'b001 = L1, anything else = L5 (latched at start)
//   i_len                 element count (latched at start)
//   i_base_a/_b/_c        A, B, C base addresses (latched at start)
//   o_rd_en               read strobe shared by the A and B RAMs
//   o_rd_addr_a/_b        read addresses
//   i_rd_data_a/_b        read data, one cycle after o_rd_en
//   o_wr_en/_addr/_data   C write port
//   o_busy                high in RUN, DRAIN and DONE
//   o_done                one-cycle pulse after the last write
//   o_range_err           sticky L1 operand range error
//
// Timing (start accepted in cycle 0): read k in cycle 1+k, write k in
//   cycle 3+k, o_done in cycle len+3 (cycle 1 when len == 0).
// -----------------------------------------------------------------------------
module sub_vec_ctrl
   import sub_vec_ctrl_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 11,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_clear,
   input  logic [2:0]            i_sec_lev,
   input  logic [LEN_WIDTH-1:0]  i_len,
   input  logic [ADDR_WIDTH-1:0] i_base_a,
   input  logic [ADDR_WIDTH-1:0] i_base_b,
   input  logic [ADDR_WIDTH-1:0] i_base_c,
   output logic                  o_rd_en,
   output logic [ADDR_WIDTH-1:0] o_rd_addr_a,
   output logic [ADDR_WIDTH-1:0] o_rd_addr_b,
   input  logic [WIDTH-1:0]      i_rd_data_a,
   input  logic [WIDTH-1:0]      i_rd_data_b,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [WIDTH-1:0]      o_wr_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_range_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]            state;
   logic [1:0]            state_nxt;

   // Operation context captured when a start is accepted.
   logic [LEN_WIDTH-1:0]  len_q;
   logic [ADDR_WIDTH-1:0] base_a_q;
   logic [ADDR_WIDTH-1:0] base_b_q;
   logic [ADDR_WIDTH-1:0] base_c_q;
   logic                  l1_q;

   logic [LEN_WIDTH-1:0]  idx;
   logic                  start_acc;
   logic                  last_issue;

   logic                  vld_p0;
   logic                  vld_p1;
   logic [ADDR_WIDTH-1:0] idx_p1;
   logic [WIDTH-1:0]      diff_p1;
   logic                  vld_p2;

   // A clear in the same cycle as a start drops the start entirely.
   assign start_acc  = (state == ST_IDLE) && i_start && !i_clear;
   assign last_issue = (idx == (len_q - LEN_WIDTH'(1)));

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else if (i_clear) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               state_nxt = (i_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_issue) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // vld_p1 is the last element still ahead of the write register;
            // once it is gone the final write is being presented this cycle,
            // so o_done lands on the cycle right after it.
            if (!vld_p0 && !vld_p1) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_rd_en = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (state)
         ST_RUN: begin
            o_rd_en = 1'b1;
            o_busy  = 1'b1;
         end
         ST_DRAIN: begin
            o_busy  = 1'b1;
         end
         ST_DONE: begin
            o_busy  = 1'b1;
            o_done  = 1'b1;
         end
         default: begin
            o_rd_en = 1'b0;
         end
      endcase
   end

   // Context latch and element index. Later changes on the input ports are
   // ignored until the next accepted start.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         len_q    <= '0;
         base_a_q <= '0;
         base_b_q <= '0;
         base_c_q <= '0;
         l1_q     <= 1'b0;
         idx      <= '0;
      end else if (start_acc) begin
         len_q    <= i_len;
         base_a_q <= i_base_a;
         base_b_q <= i_base_b;
         base_c_q <= i_base_c;
         l1_q     <= sel_l1(i_sec_lev);
         idx      <= '0;
      end else if (o_rd_en && !i_clear) begin
         idx      <= idx + LEN_WIDTH'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 0: read issue (addresses wrap modulo 2^ADDR_WIDTH)
   // ---------------------------------------------------------------------------
   assign vld_p0      = o_rd_en;
   assign o_rd_addr_a = base_a_q + ADDR_WIDTH'(idx);
   assign o_rd_addr_b = base_b_q + ADDR_WIDTH'(idx);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0 && !i_clear;
      end
   end

   always_ff @(posedge i_clk) begin
      if (vld_p0) begin
         idx_p1 <= ADDR_WIDTH'(idx);
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: RAM data arrives, modular subtraction
   // ---------------------------------------------------------------------------
   sub_vec_ctrl_sub #(
      .WIDTH (WIDTH)
   ) u_sub (
      .a     (i_rd_data_a),
      .b     (i_rd_data_b),
      .is_l1 (l1_q),
      .c     (diff_p1)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p2    <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
      end else begin
         vld_p2 <= vld_p1 && !i_clear;
         if (vld_p1) begin
            o_wr_addr <= base_c_q + idx_p1;
            o_wr_data <= diff_p1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: registered write port
   // ---------------------------------------------------------------------------
   assign o_wr_en = vld_p2;

`ifdef SUB_VEC_CTRL_RANGE_CHECK_EN
   // An L1 operand must be below 2^15; a set top bit is flagged but the
   // reduced result is still written.
   logic range_err_q;
   logic opnd_hi_p1;

   assign opnd_hi_p1 = l1_q && (i_rd_data_a[L1_Q_BITS] || i_rd_data_b[L1_Q_BITS]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         range_err_q <= 1'b0;
      end else if (i_clear || start_acc) begin
         range_err_q <= 1'b0;
      end else if (vld_p1 && opnd_hi_p1) begin
         range_err_q <= 1'b1;
      end
   end

   assign o_range_err = range_err_q;
`else
   assign o_range_err = 1'b0;
`endif

endmodule
